// File: rtl/vdrive_sequencer.sv
// rtl/vdrive_sequencer.sv - frame-level sequencer for the CCD vertical-drive controller
//
// Purpose: for each line of a frame, trigger the vertical-drive controller, wait
// for its phase sequence to wrap (7 -> 0), start horizontal readout, wait for
// readout done, idle for a programmable gap and repeat. A watchdog bounds the
// two wait states and abort returns to IDLE from anywhere.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  single-cycle frame request (accepted only in IDLE with vd_state==0)
//   abort        return to IDLE from any non-IDLE state
//   vd_state     phase state of the vertical-drive controller (0..7)
//   h_done       single-cycle pulse, horizontal readout of the line finished
//   vd_trig      single-cycle trigger to the vertical-drive controller
//   h_start      single-cycle request to horizontal readout
//   busy         high in every state except IDLE
//   line_cnt     0-based index of the current line
//   frame_done   single-cycle pulse, all lines completed
//   err          sticky watchdog flag, cleared by the next accepted frame_start
module vdrive_sequencer #(
  parameter int unsigned N_LINES = 16,
  parameter int unsigned GAP     = 20,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        abort,
  input  logic [2:0]  vd_state,
  input  logic        h_done,
  output logic        vd_trig,
  output logic        h_start,
  output logic        busy,
  output logic [11:0] line_cnt,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_V,
    S_HSTART,
    S_WAIT_H,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [15:0] CNT_TIMEOUT = 16'(TIMEOUT - 1);
  localparam logic [15:0] CNT_GAP     = 16'(GAP);
  localparam logic [11:0] LAST_LINE   = 12'(N_LINES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] line_q, line_d;
  logic        err_q, err_d;
  logic [2:0]  vd_prev_q;
  logic        vd_trig_q, h_start_q, busy_q, frame_done_q;
  logic        vdone;

  // The controller has finished a full phase cycle when it wraps from LNE back to L.
  assign vdone = (vd_prev_q == 3'd7) && (vd_state == 3'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    err_d   = err_q;

    if (abort && (state_q != S_IDLE)) begin
      // abort outranks vdone, h_done and the watchdog; line_cnt and err are left alone
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Starting while the controller is mid-cycle would confuse the vdone detection.
          if (frame_start && (vd_state == 3'd0)) begin
            state_d = S_TRIG;
            line_d  = 12'd0;
            err_d   = 1'b0;
          end
        end
        S_TRIG: begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_V;
        end
        S_WAIT_V: begin
          if (vdone) begin
            state_d = S_HSTART;
          end else if (cnt_q == CNT_TIMEOUT) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_HSTART: begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_H;
        end
        S_WAIT_H: begin
          // h_done is tested first so a done on the last watchdog cycle still counts.
          if (h_done) begin
            if (line_q == LAST_LINE) begin
              state_d = S_DONE;
            end else begin
              line_d  = line_q + 12'd1;
              cnt_d   = 16'd0;
              state_d = S_GAP;
            end
          end else if (cnt_q == CNT_TIMEOUT) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_GAP: begin
          // cnt runs 0..GAP, so a zero gap still spends one cycle here
          if (cnt_q == CNT_GAP) begin
            state_d = S_TRIG;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Pulse outputs are registered from the next state so they line up with the
  // cycle spent in the corresponding state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      line_q       <= 12'd0;
      err_q        <= 1'b0;
      vd_prev_q    <= 3'd0;
      vd_trig_q    <= 1'b0;
      h_start_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      err_q        <= err_d;
      vd_prev_q    <= vd_state;
      vd_trig_q    <= (state_d == S_TRIG);
      h_start_q    <= (state_d == S_HSTART);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  assign vd_trig    = vd_trig_q;
  assign h_start    = h_start_q;
  assign busy       = busy_q;
  assign line_cnt   = line_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vdrive_sequencer.sv
// tb/tb_vdrive_sequencer.sv - self-checking bench for vdrive_sequencer
module tb_vdrive_sequencer;

  localparam int N_LINES = 3;
  localparam int GAP     = 5;
  localparam int TIMEOUT = 50;

  localparam int EV_TRIG = 0;
  localparam int EV_HS   = 1;
  localparam int EV_FD   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  vd_state = 3'd0;
  logic        h_done = 1'b0;
  logic        vd_trig;
  logic        h_start;
  logic        busy;
  logic [11:0] line_cnt;
  logic        frame_done;
  logic        err;

  vdrive_sequencer #(
    .N_LINES(N_LINES),
    .GAP(GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .abort(abort),
    .vd_state(vd_state),
    .h_done(h_done),
    .vd_trig(vd_trig),
    .h_start(h_start),
    .busy(busy),
    .line_cnt(line_cnt),
    .frame_done(frame_done),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int line;
  } ev_t;

  typedef struct {
    logic        fs;
    logic        ab;
    logic        hd;
    logic [2:0]  vs;
    logic [4:0]  exp;    // {vd_trig, h_start, busy, frame_done, err}
    logic [11:0] eline;
  } vec_t;

  ev_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit sb_auto = 0;
  int vd_mode = 0;       // 1: controller runs its 8-phase cycle on vd_trig, 0: stuck at L
  int ph = 0;
  int rd_cnt = 0;
  int rd_delay = 10;
  int exp_line = 0;
  int n_trig = 0;
  int n_hs = 0;
  int n_fd = 0;
  int last_trig_cyc = 0;
  int last_hd_cyc = -100;
  bit fd_seen = 0;

  function automatic string ename(input int kind);
    case (kind)
      EV_TRIG: return "vd_trig";
      EV_HS:   return "h_start";
      default: return "frame_done";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int line);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.line = line;
    sb.push_back(e);
  endtask

  task automatic got_event(input int kind);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d line %0d, expected none",
               ename(kind), cyc, int'(line_cnt));
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.line != int'(line_cnt)) begin
        failures++;
        $display("FAIL event_%s: got %s at cycle %0d line %0d, expected %s at cycle %0d line %0d",
                 ename(kind), ename(kind), cyc, int'(line_cnt), ename(e.kind), e.cyc, e.line);
      end
    end
  endtask

  // One clock cycle: observe outputs on the falling edge, then advance the
  // controller and readout models and drive the inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (vd_trig) begin
        n_trig++;
        last_trig_cyc = cyc;
        got_event(EV_TRIG);
      end
      if (h_start) begin
        n_hs++;
        got_event(EV_HS);
      end
      if (frame_done) begin
        n_fd++;
        fd_seen = 1;
        got_event(EV_FD);
      end
    end
    frame_start = 1'b0;
    abort = 1'b0;
    h_done = 1'b0;
    if (vd_mode == 1) begin
      if (ph != 0) begin
        if (ph == 7) begin
          ph = 0;
          if (sb_auto) push(EV_HS, cyc + 1, exp_line);
        end else begin
          ph++;
        end
      end else if (vd_trig) begin
        ph = 1;
      end
    end
    vd_state = 3'(ph);
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        h_done = 1'b1;
        last_hd_cyc = cyc;
        if (sb_auto) begin
          if (exp_line == N_LINES - 1) begin
            push(EV_FD, cyc + 1, exp_line);
          end else begin
            exp_line++;
            push(EV_TRIG, cyc + GAP + 2, exp_line);
          end
        end
      end
    end
    if (h_start) rd_cnt = rd_delay;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    exp_line = 0;
    push(EV_TRIG, cyc + 1, 0);
  endtask

  task automatic clear_counts();
    n_trig = 0;
    n_hs = 0;
    n_fd = 0;
  endtask

  task automatic check_empty(input string name);
    check({"sb_empty_", name}, sb.size(), 0);
  endtask

  task automatic wait_done(input string name, input int budget, input bit inject);
    bit fs_done;
    bit hd_done;
    fs_done = 0;
    hd_done = 0;
    fd_seen = 0;
    last_hd_cyc = -100;
    for (int i = 0; i < budget && !fd_seen; i++) begin
      tick();
      if (inject) begin
        if (!fs_done && n_hs == 1) begin
          frame_start = 1'b1;        // request while busy
          fs_done = 1;
        end
        if (!hd_done && cyc == last_hd_cyc + 2) begin
          h_done = 1'b1;             // stray done inside GAP
          hd_done = 1;
        end
      end
    end
    check({name, "_frame_done_reached"}, int'(fd_seen), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tv[10];
    int   ign;

    tv[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 12'd0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 3'd3, 5'b00000, 12'd0};  // vd_state!=0 blocks start
    tv[2] = '{1'b0, 1'b0, 1'b1, 3'd0, 5'b00000, 12'd0};  // stray h_done in IDLE
    tv[3] = '{1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 12'd0};  // abort in IDLE
    tv[4] = '{1'b1, 1'b0, 1'b0, 3'd0, 5'b10100, 12'd0};  // accepted -> TRIG
    tv[5] = '{1'b1, 1'b0, 1'b0, 3'd0, 5'b00100, 12'd0};  // request while busy
    tv[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 5'b00100, 12'd0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 3'd7, 5'b00100, 12'd0};
    tv[8] = '{1'b0, 1'b1, 1'b0, 3'd0, 5'b00000, 12'd0};  // abort with vdone
    tv[9] = '{1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, 12'd0};  // no late h_start

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({vd_trig, h_start, busy, frame_done, err}), 0);
    check("reset_line_cnt", int'(line_cnt), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      frame_start = tv[i].fs;
      abort       = tv[i].ab;
      h_done      = tv[i].hd;
      vd_state    = tv[i].vs;
      tick();
      check($sformatf("vec%0d_outputs", i), int'({vd_trig, h_start, busy, frame_done, err}),
            int'(tv[i].exp));
      check($sformatf("vec%0d_line_cnt", i), int'(line_cnt), int'(tv[i].eline));
    end

    // nominal frame with a request while busy and a stray h_done in GAP
    mon_en = 1;
    vd_mode = 1;
    sb_auto = 1;
    ph = 0;
    tick();
    clear_counts();
    start_frame();
    wait_done("nom", 300, 1);
    tick();
    check("nom_vd_trig_count", n_trig, 3);
    check("nom_h_start_count", n_hs, 3);
    check("nom_frame_done_count", n_fd, 1);
    check("nom_busy_after", int'(busy), 0);
    check("nom_line_cnt_hold", int'(line_cnt), N_LINES - 1);
    check_empty("nom");

    // vertical watchdog
    vd_mode = 0;
    ph = 0;
    tick();
    clear_counts();
    start_frame();
    for (int i = 0; i < 5 && n_trig == 0; i++) tick();
    check("wd_trig_seen", n_trig, 1);
    while (cyc < last_trig_cyc + TIMEOUT) tick();
    check("wd_busy_before", int'(busy), 1);
    check("wd_err_before", int'(err), 0);
    tick();
    check("wd_busy_after", int'(busy), 0);
    check("wd_err_after", int'(err), 1);
    start_frame();
    tick();
    check("wd_err_cleared", int'(err), 0);
    check("wd_retrig", n_trig, 2);
    abort = 1'b1;
    tick();
    check("wd_abort_busy", int'(busy), 0);
    check("wd_no_h_start", n_hs, 0);
    check_empty("wd");
    vd_mode = 1;

    // abort during WAIT_H of line 1
    tick();
    clear_counts();
    start_frame();
    for (int i = 0; i < 200 && n_hs < 2; i++) tick();
    check("ab_line1_h_start_seen", n_hs, 2);
    repeat (3) tick();
    abort = 1'b1;
    rd_cnt = 0;
    tick();
    check("ab_busy", int'(busy), 0);
    check("ab_pulses", int'({vd_trig, h_start, frame_done}), 0);
    check("ab_line_cnt", int'(line_cnt), 1);
    repeat (30) tick();
    check("ab_no_frame_done", n_fd, 0);
    check("ab_line_cnt_hold", int'(line_cnt), 1);
    check_empty("ab");
    clear_counts();
    start_frame();
    wait_done("ab_restart", 300, 0);
    tick();
    check("ab_restart_trigs", n_trig, 3);

    // h_done on the last watchdog cycle of WAIT_H
    rd_delay = TIMEOUT;
    clear_counts();
    start_frame();
    wait_done("hto", 600, 0);
    tick();
    check("hto_err", int'(err), 0);
    check("hto_h_starts", n_hs, 3);
    check_empty("hto");
    rd_delay = 10;

    // asynchronous reset in WAIT_V of line 2
    clear_counts();
    start_frame();
    for (int i = 0; i < 300 && n_trig < 3; i++) tick();
    check("rst_line2_trig_seen", n_trig, 3);
    repeat (3) tick();
    sb_auto = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs", int'({vd_trig, h_start, busy, frame_done, err}), 0);
    check("rst_line_cnt", int'(line_cnt), 0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    ign = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vd_state == 3'd0) begin
        start_frame();
        break;
      end
      frame_start = 1'b1;
      ign++;
    end
    sb_auto = 1;
    check("rst_gated_requests", int'(ign > 0), 1);
    clear_counts();
    wait_done("rst", 300, 0);
    tick();
    check("rst_frame_trigs", n_trig, 3);
    check_empty("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
